txt_overlay: RTL and testbench
==============================

TXT_OVERLAY -- requirements
Module: txt_overlay

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning character columns displayed.
REQ-002 SHALL have parameter ROWS, default 25, meaning character rows displayed.
REQ-003 SHALL have parameter STRIDE, default 128, meaning screen-buffer words per row (power of 2, >= COLS).
REQ-004 SHALL have parameter SCALE_LOG2, default 1, meaning glyph pixel replication 2^SCALE_LOG2 in x and y (0..3).
REQ-005 SHALL have parameter BLINK_FRAMES, default 32, meaning frames per cursor blink half-period (>= 1).
REQ-006 SHALL have ports vo_clk in 1 (clock); vo_reset_ in 1 (reset); one clock, reset synchronous and active-low.
REQ-007 SHALL have ports in_vsync, in_req, in_eol, in_eof in 1 each, meaning upstream video strobes.
REQ-008 SHALL have port in_pixel in 24, meaning upstream RGB pixel.
REQ-009 SHALL have ports out_vsync, out_req, out_eol, out_eof out 1 each, meaning delayed strobes.
REQ-010 SHALL have port out_pixel out 24, meaning overlaid RGB pixel.
REQ-011 SHALL have ports wr_en in 1, wr_addr in clog2(STRIDE*ROWS), wr_data in 8, meaning screen-buffer write port.
REQ-012 SHALL have ports ovl_en in 1, ovl_transparent in 1, meaning overlay enable and transparent background.
REQ-013 SHALL have ports fg_color in 24, bg_color in 24, meaning glyph and background colours.
REQ-014 SHALL have ports cursor_en in 1, cursor_x in 7, cursor_y in 5, meaning cursor enable and cell.

Function
REQ-015 SHALL keep h_cntr (12b): +1 each in_req cycle; cleared after a cycle with in_req & in_eol.
REQ-016 SHALL keep v_cntr (11b): +1 after in_req & in_eol; cleared after in_req & in_eof or any in_vsync cycle (clear wins).
REQ-017 SHALL derive cell_x = h_cntr >> (3+SCALE_LOG2), cell_y = v_cntr >> (3+SCALE_LOG2), glyph_col/glyph_row = counter bits [SCALE_LOG2+2:SCALE_LOG2].
REQ-018 SHALL flag a pixel in-region when ovl_en & in_req & cell_x < COLS & cell_y < ROWS.
REQ-019 SHALL stage 1: read screen buffer at cell_y*STRIDE + cell_x (8b code).
REQ-020 SHALL stage 2: read font ROM (256x8 rows, 8b) at code*8 + glyph_row; bit 7 = leftmost pixel.
REQ-021 SHALL stage 3: register out_pixel and all out_* strobes; total latency exactly 3 cycles for every input, in-region or not.
REQ-022 SHALL output fg_color when glyph bit = 1 (after cursor inversion), else bg_color, or in_pixel delayed when ovl_transparent = 1.
REQ-023 SHALL output in_pixel delayed 3 cycles when not in-region.
REQ-024 SHALL invert the glyph bit when cursor_en & blink_on & cell == (cursor_x, cursor_y).
REQ-025 SHALL count frames on in_req & in_eof; toggle blink_on and restart count after BLINK_FRAMES frames.
REQ-026 SHALL write wr_data at wr_addr on wr_en, any cycle; same-address same-cycle read returns old data.
REQ-027 SHALL ignore wr_addr beyond STRIDE*ROWS-1 (no write, no wrap).
REQ-028 SHALL sample ovl_en, ovl_transparent, colours and cursor inputs at stage 1 and carry them through the pipe (no mid-pixel tearing).
REQ-029 SHALL treat cell_x >= COLS within STRIDE as off-region (pass-through).

Reset
REQ-030 SHALL on vo_reset_ = 0 at a clock edge clear h_cntr, v_cntr, frame count, blink_on, all pipeline valids, all out_* strobes and out_pixel to 0.
REQ-031 SHALL NOT clear screen-buffer or font contents; font ROM preloaded at elaboration, screen buffer loaded via write port.
REQ-032 SHALL resume correct output 3 cycles after reset deassertion, counters restarting at frame top.

Verification
REQ-033 SHALL test: SCALE_LOG2=1, write 0x41 at addr 0, fg=FFFFFF, bg=000000, glyph row 0 = 0x18 -> line 0 pixels 6..9 white, 0..5 and 10..15 black, out_req = in_req delayed 3.
REQ-034 SHALL test: ovl_transparent=1, in_pixel=123456, glyph bit 0 -> out_pixel=123456; glyph bit 1 -> fg_color.
REQ-035 SHALL test: pixel at h_cntr = COLS*16 (SCALE_LOG2=1) -> out_pixel = in_pixel delayed 3, unchanged.
REQ-036 SHALL test: cursor_en=1 at (2,1), BLINK_FRAMES=2 -> cell inverted in frames 2-3, normal in 0-1 and 4-5.
REQ-037 SHALL test: wr_en to the address being read same cycle -> old code displayed that pixel, new code next pixel.
REQ-038 SHALL test: vo_reset_ low mid-line for 1 cycle -> all outputs 0 the following cycle, h_cntr/v_cntr 0, blink_on 0.

Source files
------------

// File: rtl/txt_overlay.sv
// Character-cell text overlay: screen buffer + font ROM lookup with blinking
// cursor, mixed onto a video stream through a fixed 3-cycle pipeline.
module txt_overlay #(
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int STRIDE       = 128,
    parameter int SCALE_LOG2   = 1,
    parameter int BLINK_FRAMES = 32,
    localparam int DEPTH       = STRIDE * ROWS,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          vo_clk,
    input  logic          vo_reset_,
    input  logic          in_vsync,
    input  logic          in_req,
    input  logic          in_eol,
    input  logic          in_eof,
    input  logic [23:0]   in_pixel,
    output logic          out_vsync,
    output logic          out_req,
    output logic          out_eol,
    output logic          out_eof,
    output logic [23:0]   out_pixel,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          ovl_en,
    input  logic          ovl_transparent,
    input  logic [23:0]   fg_color,
    input  logic [23:0]   bg_color,
    input  logic          cursor_en,
    input  logic [6:0]    cursor_x,
    input  logic [4:0]    cursor_y
);

    localparam int FW = $clog2(BLINK_FRAMES) + 1;

    // Font: 'A' is a real glyph, space is blank, other codes get a fixed pattern.
    function automatic logic [7:0] font_row(input logic [7:0] code, input logic [2:0] row);
        logic [7:0] r;
        if (code == 8'h41) begin
            case (row)
                3'd0:    r = 8'h18;
                3'd1:    r = 8'h3C;
                3'd2:    r = 8'h66;
                3'd3:    r = 8'h66;
                3'd4:    r = 8'h7E;
                3'd5:    r = 8'h66;
                3'd6:    r = 8'h66;
                default: r = 8'h00;
            endcase
        end else if (code == 8'h20) begin
            r = 8'h00;
        end else begin
            r = code ^ {row, 2'b00, row};
        end
        return r;
    endfunction

    logic [7:0]    mem [DEPTH];

    logic [11:0]   h_cntr_q, h_cntr_d;
    logic [10:0]   v_cntr_q, v_cntr_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          blink_q, blink_d;

    logic [11:0]   cell_x;
    logic [10:0]   cell_y;
    logic [2:0]    glyph_col, glyph_row;
    logic          in_region, cur_hit;
    logic [AW-1:0] rd_idx;

    logic          vld_p1_q, reg_p1_q, hit_p1_q, transp_p1_q;
    logic [3:0]    stb_p1_q;
    logic [7:0]    code_p1_q;
    logic [2:0]    row_p1_q, col_p1_q;
    logic [23:0]   pix_p1_q, fg_p1_q, bg_p1_q;

    logic          vld_p2_q, reg_p2_q, hit_p2_q, transp_p2_q;
    logic [3:0]    stb_p2_q;
    logic [7:0]    font_p2_q;
    logic [2:0]    col_p2_q;
    logic [23:0]   pix_p2_q, fg_p2_q, bg_p2_q;

    logic          glyph_bit;
    logic [23:0]   pixel_d;

    always_comb begin
        h_cntr_d = h_cntr_q;
        v_cntr_d = v_cntr_q;
        frm_d    = frm_q;
        blink_d  = blink_q;
        if (in_req)
            h_cntr_d = in_eol ? '0 : h_cntr_q + 12'd1;
        if (in_vsync || (in_req && in_eof))
            v_cntr_d = '0;
        else if (in_req && in_eol)
            v_cntr_d = v_cntr_q + 11'd1;
        if (in_req && in_eof) begin
            if (frm_q == FW'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                blink_d = ~blink_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    always_comb begin
        cell_x    = h_cntr_q >> (3 + SCALE_LOG2);
        cell_y    = v_cntr_q >> (3 + SCALE_LOG2);
        glyph_col = h_cntr_q[SCALE_LOG2+2 -: 3];
        glyph_row = v_cntr_q[SCALE_LOG2+2 -: 3];
        in_region = ovl_en && in_req && (cell_x < 12'(COLS)) && (cell_y < 11'(ROWS));
        cur_hit   = cursor_en && blink_q && (cell_x == {5'b0, cursor_x})
                    && (cell_y == {6'b0, cursor_y});
        rd_idx    = in_region ? AW'(32'(cell_y) * 32'(STRIDE) + 32'(cell_x)) : '0;
    end

    always_ff @(posedge vo_clk) begin
        if (!vo_reset_) begin
            h_cntr_q <= '0;
            v_cntr_q <= '0;
            frm_q    <= '0;
            blink_q  <= 1'b0;
        end else begin
            h_cntr_q <= h_cntr_d;
            v_cntr_q <= v_cntr_d;
            frm_q    <= frm_d;
            blink_q  <= blink_d;
        end
    end

    // Screen buffer: nonblocking read-before-write gives old data on a same-address hit.
    always_ff @(posedge vo_clk) begin
        if (wr_en && (32'(wr_addr) < 32'(DEPTH)))
            mem[wr_addr] <= wr_data;
    end

    // Stage 1: screen-buffer read, controls sampled for this pixel
    always_ff @(posedge vo_clk) begin
        code_p1_q   <= mem[rd_idx];
        row_p1_q    <= glyph_row;
        col_p1_q    <= glyph_col;
        pix_p1_q    <= in_pixel;
        reg_p1_q    <= in_region;
        hit_p1_q    <= cur_hit;
        transp_p1_q <= ovl_transparent;
        fg_p1_q     <= fg_color;
        bg_p1_q     <= bg_color;
        if (!vo_reset_) begin
            vld_p1_q <= 1'b0;
            stb_p1_q <= '0;
        end else begin
            vld_p1_q <= 1'b1;
            stb_p1_q <= {in_vsync, in_req, in_eol, in_eof};
        end
    end

    // Stage 2: font row lookup
    always_ff @(posedge vo_clk) begin
        font_p2_q   <= font_row(code_p1_q, row_p1_q);
        col_p2_q    <= col_p1_q;
        pix_p2_q    <= pix_p1_q;
        reg_p2_q    <= reg_p1_q;
        hit_p2_q    <= hit_p1_q;
        transp_p2_q <= transp_p1_q;
        fg_p2_q     <= fg_p1_q;
        bg_p2_q     <= bg_p1_q;
        if (!vo_reset_) begin
            vld_p2_q <= 1'b0;
            stb_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            stb_p2_q <= stb_p1_q;
        end
    end

    // Stage 3: pixel select and output registers
    always_comb begin
        glyph_bit = font_p2_q[3'd7 - col_p2_q] ^ hit_p2_q;
        pixel_d   = '0;
        if (vld_p2_q) begin
            if (!reg_p2_q)
                pixel_d = pix_p2_q;
            else if (glyph_bit)
                pixel_d = fg_p2_q;
            else
                pixel_d = transp_p2_q ? pix_p2_q : bg_p2_q;
        end
    end

    always_ff @(posedge vo_clk) begin
        if (!vo_reset_) begin
            {out_vsync, out_req, out_eol, out_eof} <= '0;
            out_pixel <= '0;
        end else begin
            {out_vsync, out_req, out_eol, out_eof} <= stb_p2_q;
            out_pixel <= pixel_d;
        end
    end

endmodule

// File: tb/tb_txt_overlay.sv
// Bench for txt_overlay: random and directed video traffic checked against a
// pixel-level reference model of the overlay behaviour.
module tb_txt_overlay;

    localparam int COLS = 80, ROWS = 25, STRIDE = 128, BF = 2;
    localparam int DEPTH = STRIDE * ROWS;

    typedef struct packed {
        logic [3:0]  stb;
        logic [23:0] pix;
    } ov_t;

    logic        clk = 1'b0, rst_n;
    logic        in_vsync, in_req, in_eol, in_eof;
    logic [23:0] in_pixel;
    logic        out_vsync, out_req, out_eol, out_eof;
    logic [23:0] out_pixel;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        ovl_en, ovl_transparent;
    logic [23:0] fg_color, bg_color;
    logic        cursor_en;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    txt_overlay #(.COLS(COLS), .ROWS(ROWS), .STRIDE(STRIDE), .SCALE_LOG2(1), .BLINK_FRAMES(BF)) dut (
        .vo_clk(clk), .vo_reset_(rst_n),
        .in_vsync(in_vsync), .in_req(in_req), .in_eol(in_eol), .in_eof(in_eof), .in_pixel(in_pixel),
        .out_vsync(out_vsync), .out_req(out_req), .out_eol(out_eol), .out_eof(out_eof), .out_pixel(out_pixel),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ovl_en(ovl_en), .ovl_transparent(ovl_transparent),
        .fg_color(fg_color), .bg_color(bg_color),
        .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clk = ~clk;

    int          ncmp = 0, nfail = 0;
    int          cyc = 0;
    ov_t         exp_v [8];
    bit          exp_ok [8];
    int          mh = 0, mv = 0, mframe = 0;
    bit          mblink = 0;
    logic [7:0]  mem_m [DEPTH];
    ov_t         got_q[$], want_q[$];
    int          cyc_q[$];
    logic [23:0] cap_q[$], sent_q[$];
    ov_t         g, w;
    int          c;

    function automatic logic [7:0] font_ref(input logic [7:0] code, input int row);
        logic [7:0] a_rows [8] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
        if (code == 8'h41) return a_rows[row];
        if (code == 8'h20) return 8'h00;
        return code ^ 8'((row << 5) | row);
    endfunction

    // Advance one clock: predict the output 3 cycles ahead, then record what the DUT shows now.
    task automatic step();
        int cx, cy, bitv;
        logic [23:0] px;
        if (!rst_n) begin
            for (int k = 1; k <= 3; k++) begin
                exp_v[(cyc + k) % 8]  = '0;
                exp_ok[(cyc + k) % 8] = 1'b1;
            end
            mh = 0; mv = 0; mframe = 0; mblink = 0;
        end else begin
            cx = mh >> 4;
            cy = mv >> 4;
            px = in_pixel;
            if (ovl_en && in_req && cx < COLS && cy < ROWS) begin
                bitv = (font_ref(mem_m[cy * STRIDE + cx], (mv >> 1) % 8) >> (7 - (mh >> 1) % 8)) & 1;
                if (cursor_en && mblink && cx == int'(cursor_x) && cy == int'(cursor_y)) bitv ^= 1;
                px = bitv ? fg_color : (ovl_transparent ? in_pixel : bg_color);
            end
            exp_v[(cyc + 3) % 8]  = {in_vsync, in_req, in_eol, in_eof, px};
            exp_ok[(cyc + 3) % 8] = 1'b1;
            if (in_req) mh = in_eol ? 0 : (mh + 1) % 4096;
            if (in_vsync || (in_req && in_eof)) mv = 0;
            else if (in_req && in_eol) mv = (mv + 1) % 2048;
            if (in_req && in_eof) begin
                mframe++;
                if (mframe == BF) begin mframe = 0; mblink = !mblink; end
            end
        end
        if (wr_en && int'(wr_addr) < DEPTH) mem_m[wr_addr] = wr_data;
        if (in_req) sent_q.push_back(in_pixel);
        @(posedge clk); #1;
        cyc++;
        if (exp_ok[cyc % 8]) begin
            got_q.push_back({out_vsync, out_req, out_eol, out_eof, out_pixel});
            want_q.push_back(exp_v[cyc % 8]);
            cyc_q.push_back(cyc);
            exp_ok[cyc % 8] = 1'b0;
        end
        if (out_req) cap_q.push_back(out_pixel);
    endtask

    task automatic set_idle();
        in_vsync = 0; in_req = 0; in_eol = 0; in_eof = 0; wr_en = 0;
        in_pixel = 24'($urandom);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        step();
        rst_n = 1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (4) begin
            in_req = 1'($urandom); in_eol = 1'($urandom); in_vsync = 1'($urandom);
            in_eof = 1'($urandom); in_pixel = 24'($urandom);
            step();
        end
        ncmp++;
        if ({out_vsync, out_req, out_eol, out_eof, out_pixel} !== 28'h0) begin
            nfail++;
            $display("FAIL reset_outputs got %b/%h want 0/000000",
                     {out_vsync, out_req, out_eol, out_eof}, out_pixel);
        end
        rst_n = 1;
        set_idle();
        repeat (4) step();
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL reset_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    task automatic test_fill();
        ovl_en = 0;
        for (int a = 0; a < DEPTH; a++) begin
            set_idle();
            in_req = 1'($urandom);
            in_eol = ($urandom_range(0, 39) == 0);
            wr_en = 1; wr_addr = 12'(a);
            case ($urandom_range(0, 3))
                0:       wr_data = 8'h41;
                1:       wr_data = 8'h20;
                default: wr_data = 8'($urandom);
            endcase
            step();
        end
        set_idle();
        repeat (3) step();
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL fill_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    task automatic test_glyph();
        logic [23:0] want;
        do_reset();
        wr_en = 1; wr_addr = 0; wr_data = 8'h41;
        step();
        ovl_en = 1; ovl_transparent = 0; fg_color = 24'hFFFFFF; bg_color = 24'h000000; cursor_en = 0;
        cap_q.delete();
        for (int p = 0; p < 16; p++) begin
            set_idle(); in_req = 1; in_eol = (p == 15);
            step();
        end
        set_idle();
        repeat (3) step();
        ncmp++;
        if (cap_q.size() != 16) begin nfail++;
            $display("FAIL glyph_count got %0d want 16", cap_q.size()); end
        for (int p = 0; p < 16 && p < cap_q.size(); p++) begin
            want = (p >= 6 && p <= 9) ? 24'hFFFFFF : 24'h000000;
            ncmp++;
            if (cap_q[p] !== want) begin nfail++;
                $display("FAIL glyph_px%0d got %h want %h", p, cap_q[p], want); end
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL glyph_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    task automatic test_transparent();
        do_reset();
        ovl_en = 1; ovl_transparent = 1; fg_color = 24'hABCDEF; bg_color = 24'h0F0F0F;
        cap_q.delete();
        for (int p = 0; p < 16; p++) begin
            set_idle(); in_req = 1; in_eol = (p == 15); in_pixel = 24'h123456;
            step();
        end
        set_idle();
        repeat (3) step();
        ncmp++;
        if (cap_q.size() < 7 || cap_q[0] !== 24'h123456) begin nfail++;
            $display("FAIL transp_bg got %h want 123456", cap_q.size() > 0 ? cap_q[0] : 24'h0); end
        ncmp++;
        if (cap_q.size() < 7 || cap_q[6] !== 24'hABCDEF) begin nfail++;
            $display("FAIL transp_fg got %h want abcdef", cap_q.size() > 6 ? cap_q[6] : 24'h0); end
        ovl_transparent = 0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL transp_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    task automatic test_offregion();
        do_reset();
        ovl_en = 1; fg_color = 24'hFFFFFF; bg_color = 24'h000000;
        cap_q.delete(); sent_q.delete();
        for (int p = 0; p < 1290; p++) begin
            set_idle(); in_req = 1; in_eol = (p == 1289);
            step();
        end
        set_idle();
        repeat (3) step();
        ncmp++;
        if (cap_q.size() < 1281 || sent_q.size() < 1281 || cap_q[COLS * 16] !== sent_q[COLS * 16]) begin
            nfail++;
            $display("FAIL offregion_px got %h want %h",
                     cap_q.size() > 1280 ? cap_q[1280] : 24'h0, sent_q.size() > 1280 ? sent_q[1280] : 24'h0);
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL offregion_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    task automatic test_cursor();
        logic [23:0] want;
        do_reset();
        wr_en = 1; wr_addr = 12'(1 * STRIDE + 2); wr_data = 8'h20;
        step();
        ovl_en = 1; ovl_transparent = 0; fg_color = 24'hFFFFFF; bg_color = 24'h000000;
        cursor_en = 1; cursor_x = 2; cursor_y = 1;
        cap_q.delete();
        for (int f = 0; f < 6; f++)
            for (int l = 0; l < 17; l++)
                for (int p = 0; p < 33; p++) begin
                    set_idle(); in_req = 1; in_eol = (p == 32); in_eof = (p == 32 && l == 16);
                    step();
                end
        set_idle();
        repeat (3) step();
        for (int f = 0; f < 6; f++) begin
            want = (f == 2 || f == 3) ? 24'hFFFFFF : 24'h000000;
            ncmp++;
            if (cap_q.size() < 6 * 561 || cap_q[f * 561 + 560] !== want) begin nfail++;
                $display("FAIL cursor_frame%0d got %h want %h", f,
                         cap_q.size() > f * 561 + 560 ? cap_q[f * 561 + 560] : 24'h0, want); end
        end
        cursor_en = 0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL cursor_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    task automatic test_write_collision();
        do_reset();
        wr_en = 1; wr_addr = 0; wr_data = 8'h41;
        step();
        ovl_en = 1; ovl_transparent = 0; fg_color = 24'hFFFFFF; bg_color = 24'h000000; cursor_en = 0;
        cap_q.delete();
        set_idle(); in_req = 1; wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
        step();
        set_idle(); in_req = 1; in_eol = 1;
        step();
        set_idle();
        repeat (3) step();
        ncmp++;
        if (cap_q.size() != 2 || cap_q[0] !== 24'h000000) begin nfail++;
            $display("FAIL collide_old got %h want 000000", cap_q.size() > 0 ? cap_q[0] : 24'h0); end
        ncmp++;
        if (cap_q.size() != 2 || cap_q[1] !== 24'hFFFFFF) begin nfail++;
            $display("FAIL collide_new got %h want ffffff", cap_q.size() > 1 ? cap_q[1] : 24'h0); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL collide_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        wr_en = 1; wr_addr = 0; wr_data = 8'h20;
        step();
        ovl_en = 1; ovl_transparent = 0; fg_color = 24'h00FF00; bg_color = 24'h202020;
        cursor_en = 1; cursor_x = 0; cursor_y = 0;
        repeat (2) begin
            set_idle(); in_req = 1; in_eol = 1; in_eof = 1;
            step();
        end
        for (int p = 0; p < 5; p++) begin
            set_idle(); in_req = 1; in_vsync = (p == 0);
            step();
        end
        set_idle(); in_req = 1; rst_n = 0;
        step();
        rst_n = 1;
        ncmp++;
        if ({out_vsync, out_req, out_eol, out_eof, out_pixel} !== 28'h0) begin nfail++;
            $display("FAIL midreset_outputs got %b/%h want 0/000000",
                     {out_vsync, out_req, out_eol, out_eof}, out_pixel); end
        for (int p = 0; p < 20; p++) begin
            set_idle(); in_req = 1; in_eol = (p == 19);
            step();
        end
        set_idle();
        repeat (3) step();
        cursor_en = 0;
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL midreset_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            set_idle();
            rst_n           = ($urandom_range(0, 599) != 0);
            in_req          = ($urandom_range(0, 4) != 0);
            in_eol          = ($urandom_range(0, 24) == 0);
            in_eof          = ($urandom_range(0, 199) == 0);
            in_vsync        = ($urandom_range(0, 399) == 0);
            ovl_en          = ($urandom_range(0, 7) != 0);
            ovl_transparent = 1'($urandom);
            fg_color        = 24'($urandom);
            bg_color        = 24'($urandom);
            cursor_en       = 1'($urandom);
            cursor_x        = 7'($urandom_range(0, 2));
            cursor_y        = 5'($urandom_range(0, 1));
            wr_en           = ($urandom_range(0, 9) == 0);
            wr_addr         = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(DEPTH, 4095))
                                                          : 12'($urandom_range(0, 300));
            wr_data         = 8'($urandom);
            step();
        end
        rst_n = 1;
        set_idle();
        repeat (3) step();
        while (got_q.size() > 0) begin
            g = got_q.pop_front(); w = want_q.pop_front(); c = cyc_q.pop_front(); ncmp++;
            if (g !== w) begin nfail++;
                $display("FAIL random_model cyc=%0d got %b/%h want %b/%h", c, g.stb, g.pix, w.stb, w.pix); end
        end
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        wr_addr = 0; wr_data = 0; ovl_en = 0; ovl_transparent = 0;
        fg_color = 0; bg_color = 0; cursor_en = 0; cursor_x = 0; cursor_y = 0;
        @(posedge clk); #1;
        test_reset();
        test_fill();
        test_glyph();
        test_transparent();
        test_offregion();
        test_cursor();
        test_write_collision();
        test_reset_midline();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
